// File: rtl/board_pkg.sv
// Shared board definitions for the maze game.
//
// Holds the block-type codes stored in each board cell, the board
// geometry constants and the state encoding of the board init loader.
// No ports; imported with "import board_pkg::*;".
package board_pkg;

  localparam int BOARD_W     = 32;
  localparam int BOARD_H     = 24;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;
  localparam int BLOCK_W     = 4;

  // Cell contents as stored in the layout ROM and board RAMs.
  typedef enum logic [BLOCK_W-1:0] {
    EMPTY  = 4'd0,
    WALL   = 4'd1,
    PELLET = 4'd2,
    POWER  = 4'd3,
    PACMAN = 4'd4,
    GHOST  = 4'd5
  } block_t;

  // Loader sequencing: issue reads, wait for the ROM pipe to empty,
  // pulse done for one cycle, then idle with the port handed to game logic.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FINISH = 2'd2,
    ST_IDLE   = 2'd3
  } load_state_t;

endpackage

// File: rtl/lat_pipe.sv
// Delay line that tracks outstanding layout-ROM reads.
//
// Carries {valid, addr} DEPTH stages so that the address of each read
// lines up with the ROM data returned DEPTH cycles later.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low clear of every stage
//   in_valid  - a read is issued this cycle
//   in_addr   - address of that read
//   out_valid - the read issued DEPTH cycles ago is returning now
//   out_addr  - address of the returning read
//   any_valid - at least one read is still in flight
module lat_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              any_valid
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  // "Empty" counts the output stage too, so DRAIN lasts one cycle past the last write.
  assign any_valid = |valid_q;

endmodule

// File: rtl/board_init_loader.sv
// Board init loader: copies the maze layout ROM into the board RAM write
// port one cell per cycle after reset and on every new-game request, then
// hands the write port to game logic through a zero-latency mux.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low reset (restarts the load)
//   start        - new-game request, honoured only while idle
//   rom_addr     - layout ROM read address
//   rom_q        - layout ROM data, valid ROM_LAT cycles after rom_addr
//   game_addr    - game-logic write address
//   game_data    - game-logic write data
//   game_wren    - game-logic write enable (dropped while busy)
//   ram_addr     - board RAM write address (both RAM copies)
//   ram_data     - board RAM write data
//   ram_wren     - board RAM write enable
//   busy         - loader owns the write port
//   done         - one-cycle pulse when a load completes
//   pellet_count - pellet cells written by the most recent load
module board_init_loader
  import board_pkg::*;
#(
  parameter int CELLS   = 768,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_data,
  input  logic              game_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pellet_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(CELLS - 1);
  localparam logic [DATA_W-1:0] PELLET_CODE = DATA_W'(PELLET);

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pellet_q, pellet_d;

  logic              issue;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              pipe_busy;

  lat_pipe #(
    .DEPTH  (ROM_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_addr   (cnt_q),
    .out_valid (wr_valid),
    .out_addr  (wr_addr),
    .any_valid (pipe_busy)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pellet_d = pellet_q;
    issue    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      ST_FILL: begin
        issue = 1'b1;
        // Counter parks on the last address rather than wrapping.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d  = ST_FILL;
          cnt_d    = '0;
          pellet_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Returning reads only exist during FILL/DRAIN, so this cannot fire
    // on the same cycle that IDLE clears the count.
    if (wr_valid && (rom_q == PELLET_CODE)) begin
      pellet_d = pellet_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      pellet_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pellet_q <= pellet_d;
    end
  end

  // Write-port mux: loader while busy, game logic otherwise (incl. the done cycle).
  always_comb begin
    if (busy) begin
      ram_addr = wr_addr;
      ram_data = rom_q;
      ram_wren = wr_valid;
    end else begin
      ram_addr = game_addr;
      ram_data = game_data;
      ram_wren = game_wren;
    end
  end

  assign rom_addr     = cnt_q;
  assign pellet_count = pellet_q;

endmodule

// File: tb/tb_board_init_loader.sv
// Testbench for board_init_loader. Two instances run side by side, one
// with a 1-cycle layout ROM and one with a 2-cycle ROM, against a
// cycle-count based reference model of a load.
module tb_board_init_loader;

  localparam int CELLS  = 768;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] game_addr = '0;
  logic [DATA_W-1:0] game_data = '0;
  logic game_wren = 1'b0;
  bit game_hold = 1'b1;

  logic [ADDR_W-1:0] rom_addr_a, ram_addr_a, pellet_a;
  logic [DATA_W-1:0] rom_q_a, ram_data_a;
  logic ram_wren_a, busy_a, done_a;

  logic [ADDR_W-1:0] rom_addr_b, ram_addr_b, pellet_b;
  logic [DATA_W-1:0] rom_q_b, ram_data_b, rom_b_s1;
  logic ram_wren_b, busy_b, done_b;

  logic [DATA_W-1:0] rom_mem [2][CELLS];
  logic [DATA_W-1:0] snap [2][CELLS];
  logic [DATA_W-1:0] shadow_a [CELLS];
  int model_cyc [2];
  bit model_idle [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  board_init_loader #(.CELLS(CELLS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a),
    .game_addr(game_addr), .game_data(game_data), .game_wren(game_wren),
    .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a),
    .busy(busy_a), .done(done_a), .pellet_count(pellet_a)
  );

  board_init_loader #(.CELLS(CELLS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b),
    .game_addr(game_addr), .game_data(game_data), .game_wren(game_wren),
    .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
    .busy(busy_b), .done(done_b), .pellet_count(pellet_b)
  );

  // Layout ROMs with one and two cycles of read latency.
  always @(posedge clk) begin
    rom_q_a  <= rom_mem[0][rom_addr_a];
    rom_b_s1 <= rom_mem[1][rom_addr_b];
    rom_q_b  <= rom_b_s1;
  end

  // Reference model: each load is tracked only as "cycles since the load
  // began"; index CELLS+lat+1 is the done cycle, after which the loader idles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset || (model_idle[d] && start)) begin
        model_cyc[d]  <= 0;
        model_idle[d] <= 1'b0;
        for (int i = 0; i < CELLS; i++) snap[d][i] <= rom_mem[d][i];
      end else if (!model_idle[d]) begin
        if (model_cyc[d] == CELLS + d + 2) model_idle[d] <= 1'b1;
        else model_cyc[d] <= model_cyc[d] + 1;
      end
    end
  end

  function automatic int countPellets(input int d, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (snap[d][i] == 4'd2) k++;
    return k;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic compareDut(input int d, input logic busy_o, input logic done_o,
                            input logic [ADDR_W-1:0] pellet_o, input logic [ADDR_W-1:0] rom_addr_o,
                            input logic [ADDR_W-1:0] ram_addr_o, input logic [DATA_W-1:0] ram_data_o,
                            input logic ram_wren_o);
    int lat, c, n;
    logic exp_busy, exp_done, exp_wren, chk_rom;
    int exp_addr, exp_data, exp_pellet;
    lat = d + 1;
    chk_rom = 1'b0;
    exp_addr = 0;
    exp_data = 0;
    if (!reset) begin
      exp_busy = 1'b1; exp_done = 1'b0; exp_wren = 1'b0; exp_pellet = 0; chk_rom = 1'b1;
    end else if (model_idle[d]) begin
      exp_busy = 1'b0; exp_done = 1'b0;
      exp_wren = game_wren; exp_addr = game_addr; exp_data = game_data;
      exp_pellet = countPellets(d, CELLS);
    end else begin
      c = model_cyc[d];
      exp_busy = (c <= CELLS + lat);
      exp_done = (c == CELLS + lat + 1);
      if (exp_done) begin
        exp_wren = game_wren; exp_addr = game_addr; exp_data = game_data;
      end else if (c >= lat && c < CELLS + lat) begin
        exp_wren = 1'b1; exp_addr = c - lat; exp_data = snap[d][c - lat];
      end else begin
        exp_wren = 1'b0;
      end
      if (c < CELLS) begin
        chk_rom = 1'b1;
        exp_addr = exp_wren ? exp_addr : 0;
      end
      n = c - lat;
      if (n < 0) n = 0;
      if (n > CELLS) n = CELLS;
      exp_pellet = countPellets(d, n);
    end
    checkOutput("busy", d, busy_o, exp_busy);
    checkOutput("done", d, done_o, exp_done);
    checkOutput("ram_wren", d, ram_wren_o, exp_wren);
    checkOutput("pellet_count", d, pellet_o, exp_pellet);
    if (chk_rom) checkOutput("rom_addr", d, rom_addr_o, reset ? model_cyc[d] : 0);
    if (exp_wren) begin
      checkOutput("ram_addr", d, ram_addr_o, exp_addr);
      checkOutput("ram_data", d, ram_data_o, exp_data);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    compareDut(0, busy_a, done_a, pellet_a, rom_addr_a, ram_addr_a, ram_data_a, ram_wren_a);
    compareDut(1, busy_b, done_b, pellet_b, rom_addr_b, ram_addr_b, ram_data_b, ram_wren_b);
  end

  // Game-logic write traffic; held at a fixed address when requested.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      game_data = DATA_W'($urandom_range(0, 15));
      if (game_hold) begin
        game_addr = ADDR_W'(5);
        game_wren = 1'b1;
      end else begin
        game_addr = ADDR_W'($urandom_range(0, 1023));
        game_wren = 1'($urandom_range(0, 1));
      end
    end
  end

  // Random layout with extra pellets and one out-of-range code at cell 10.
  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CELLS; i++) begin
        rom_mem[d][i] = ($urandom_range(0, 3) == 0) ? 4'd2 : DATA_W'($urandom_range(0, 15));
      end
      rom_mem[d][10] = 4'hF;
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int first_a, first_b, done_at_a, done_at_b, writes_a, exp_p;
    bit hit;

    // Load after reset: addr%6 in the fast ROM, all walls in the slow ROM.
    for (int i = 0; i < CELLS; i++) begin
      rom_mem[0][i] = DATA_W'(i % 6);
      rom_mem[1][i] = 4'd1;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 0, busy_a, 1);
    checkOutput("reset_pellet", 0, pellet_a, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    first_a = -1; first_b = -1; done_at_a = -1; done_at_b = -1;
    for (int c = 0; c < 1000 && (done_at_a < 0 || done_at_b < 0); c++) begin
      @(negedge clk);
      if (busy_a && ram_wren_a && first_a < 0) first_a = c;
      if (busy_b && ram_wren_b && first_b < 0) first_b = c;
      if (done_a && done_at_a < 0) begin
        done_at_a = c;
        checkOutput("done_cycle_game_addr", 0, ram_addr_a, 5);
        checkOutput("done_cycle_game_wren", 0, ram_wren_a, 1);
      end
      if (done_b && done_at_b < 0) done_at_b = c;
    end
    checkOutput("first_write_cycle", 0, first_a, 1);
    checkOutput("first_write_cycle", 1, first_b, 2);
    checkOutput("done_cycle", 0, done_at_a, 770);
    checkOutput("done_cycle", 1, done_at_b, 771);
    repeat (2) @(negedge clk);
    checkOutput("final_pellets_mod6", 0, pellet_a, 128);
    checkOutput("final_pellets_walls", 1, pellet_b, 0);
    game_hold = 1'b0;

    // Random loads started from IDLE with an ignored second start.
    for (int r = 0; r < 2; r++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput("busy_after_start", 0, busy_a, 1);
      checkOutput("pellet_cleared", 0, pellet_a, 0);
      done_at_a = -1; writes_a = 0;
      for (int i = 0; i < CELLS; i++) shadow_a[i] = '0;
      for (int c = 0; c < 1000 && done_at_a < 0; c++) begin
        if (c > 0) @(negedge clk);
        start = (c == 100);
        if (busy_a && ram_wren_a) begin
          shadow_a[ram_addr_a] = ram_data_a;
          writes_a++;
        end
        if (done_a) done_at_a = c;
      end
      start = 1'b0;
      checkOutput("restart_done_cycle", 0, done_at_a, 770);
      checkOutput("write_count", 0, writes_a, CELLS);
      checkOutput("cell10_code_f", 0, shadow_a[10], 15);
      exp_p = 0;
      for (int i = 0; i < CELLS; i++) if (rom_mem[0][i] == 4'd2) exp_p++;
      checkOutput("random_pellets", 0, pellet_a, exp_p);
      repeat (4) @(negedge clk);
    end

    // Reset in the middle of a load, at write address 300.
    applyStimulus();
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      if (busy_a && ram_wren_a && ram_addr_a == 300) hit = 1'b1;
    end
    checkOutput("reached_addr_300", 0, hit, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midload_reset_wren", 0, ram_wren_a, 0);
      checkOutput("midload_reset_rom_addr", 0, rom_addr_a, 0);
      checkOutput("midload_reset_pellet", 0, pellet_a, 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    first_a = -1; writes_a = 0; done_at_a = -1;
    for (int c = 0; c < 1000 && done_at_a < 0; c++) begin
      @(negedge clk);
      if (busy_a && ram_wren_a) begin
        if (first_a < 0) first_a = ram_addr_a;
        writes_a++;
      end
      if (done_a) done_at_a = c;
    end
    checkOutput("rewrite_first_addr", 0, first_a, 0);
    checkOutput("rewrite_count", 0, writes_a, CELLS);
    checkOutput("rewrite_done_cycle", 0, done_at_a, 770);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/board_init_loader.md
# board_init_loader

Copies the initial maze layout from a synchronous layout ROM into the board RAM write port, one cell per cycle, after reset and on every new-game request. It sits directly upstream of the board RAMs (the VGA-read copy and the game-logic-read copy). While a load is in progress it owns the shared write port; once the load finishes it hands the port to game logic through a pass-through mux. It also reports how many pellet cells were loaded, so the win-condition logic has a target count.

## Interface
- `CELLS`, default 768: board cells (32 x 24), loaded from address 0 to CELLS-1.
- `ADDR_W`, default 10: width of the ROM and RAM address.
- `DATA_W`, default 4: width of a block-type code.
- `ROM_LAT`, default 1: read latency of the layout ROM in cycles. Legal values are 1 and 2.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: new-game request. It is sampled only in IDLE.
- `rom_addr` out ADDR_W: layout ROM read address.
- `rom_q` in DATA_W: layout ROM data. It is valid ROM_LAT cycles after `rom_addr`.
- `game_addr` in ADDR_W: game-logic write address.
- `game_data` in DATA_W: game-logic write data.
- `game_wren` in 1: game-logic write enable.
- `ram_addr` out ADDR_W: board RAM write address. It fans out to both RAM copies.
- `ram_data` out DATA_W: board RAM write data.
- `ram_wren` out 1: board RAM write enable.
- `busy` out 1: high while the loader owns the write port.
- `done` out 1: one-cycle pulse when a load completes.
- `pellet_count` out ADDR_W: number of PELLET cells written by the most recent load.

## Operation
- FSM states: FILL, DRAIN, FINISH, IDLE.
- Reset asserted (async):
  - State goes to FILL with the read counter at 0.
  - `busy`=1, `done`=0, `pellet_count`=0, `rom_addr`=0, and the valid pipeline is cleared.
  - A load therefore starts automatically when reset is released.
- FILL:
  - Drives `rom_addr` = read counter and pushes a valid bit into a ROM_LAT-deep pipeline.
  - Increments the counter by 1 each cycle.
  - On the cycle that issues address CELLS-1, moves to DRAIN.
- DRAIN: issues no new reads. Moves to FINISH once the valid pipeline is empty.
- Write stage (FILL and DRAIN), whenever the pipeline output is valid:
  - `ram_wren`=1, `ram_addr` = the delayed address, `ram_data` = `rom_q`.
  - If `rom_q` == PELLET, `pellet_count` increments by 1.
- FINISH: lasts one cycle with `done`=1 and `busy`=0, then moves to IDLE.
- IDLE:
  - `ram_addr`, `ram_data` and `ram_wren` are combinational copies of the `game_*` inputs.
  - `start`=1 causes the next cycle to be FILL with the counter at 0 and `pellet_count` cleared to 0.
- While `busy`=1, `game_wren` is ignored. Game writes are dropped, not queued.
- `start` is ignored in FILL, DRAIN and FINISH. Back-to-back `start` during a load does not restart it.
- Reset asserted mid-load aborts immediately. Release restarts the load from address 0; partially written RAM contents are overwritten.
- ROM codes outside the defined block types are written through unchanged and never counted.

## Timing
- First RAM write occurs ROM_LAT cycles after the first FILL cycle.
- Writes are consecutive, one per cycle, with no gaps: CELLS writes in total.
- Load duration from the first FILL cycle to the `done` pulse is CELLS + ROM_LAT + 1 cycles (770 with the defaults).
- `pellet_count` is final on the `done` cycle and holds until the next load starts.
- FINISH and IDLE port mux has zero added latency. Game writes issued on the `done` cycle are passed through.
- Counter width is ADDR_W, with no wrap. CELLS must be ≤ 2^ADDR_W. CELLS-1 is the last address issued.

## Structure
- The shared package `board_pkg` holds:
  - `block_t` enum (DATA_W bits): EMPTY=0, WALL=1, PELLET=2, POWER=3, PACMAN=4, GHOST=5.
  - Constants BOARD_W=32, BOARD_H=24, BOARD_CELLS=768.
  - The loader FSM state enum.
- One sub-module: `lat_pipe`, a parameterised ROM_LAT-deep shift register carrying {valid, addr}, with async active-low clear.
- The write-port mux lives in `board_init_loader` itself.

## Test plan
- Reset release with a ROM model (ROM_LAT=1) holding addr%6:
  - Writes 0..767 on consecutive cycles, each with data addr%6.
  - `done` arrives 770 cycles after release.
  - `pellet_count` is 128.
- ROM_LAT=2 with all-WALL content:
  - First write comes 2 cycles after FILL starts.
  - `done` arrives at cycle 771.
  - `pellet_count`=0.
- `game_wren`=1 held throughout a load with `game_addr`=5:
  - No game write reaches the RAM before `done`.
  - On the `done` cycle, `ram_addr`=5 with `ram_wren`=1.
- In IDLE, pulse `start`:
  - `busy` rises the next cycle.
  - `pellet_count` clears to 0, then reaches the new count.
  - A second `start` pulse at cycle 100 of the load has no effect; the total is still 770 cycles.
- Assert `reset` at write address 300, hold 3 cycles, release:
  - All outputs are at reset values during reset.
  - Rewrite begins at address 0, and the full 768 writes complete.
- ROM containing code 0xF at address 10: RAM receives 0xF, and it is not counted as a pellet.
